// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU result responder slice.
package fpu_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_WAIT = 2'd1,
        RS_ACK  = 2'd2
    } respStateType;

    // Source tag stored alongside each captured result.
    localparam logic SRC_M1 = 1'b0;   // adder
    localparam logic SRC_M2 = 1'b1;   // multiplier

endpackage : fpu_pkg

// File: rtl/fpu_result_responder_fifo.sv
// Result FIFO: circular buffer with wrap-around pointers and an occupancy count.
// The head is read straight from the storage array, so a pushed entry shows up
// at the head the cycle after the push with no bypass path.
module resp_fifo
    import fpu_pkg::*;
#(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_en;
    logic          pop_en;

    // Full/empty flags come from the registered count, so a same-cycle pop never unblocks a push.
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage write; contents need no reset because the count masks stale entries.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Next pointer and count values; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : resp_fifo

// File: rtl/fpu_result_responder.sv
// Slave end of the M1/M2 request interconnect: waits ACK_DELAY cycles of a held
// S_req, captures the selected master's result into the result FIFO with a
// source tag, and answers with a registered one-cycle S_ack.
module fpu_result_responder
    import fpu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int ACK_DELAY = 2
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic                       S_req,
    input  logic                       Select,
    output logic                       S_ack,
    input  logic [DATA_W-1:0]          M1_data,
    input  logic [DATA_W-1:0]          M2_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_src,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       busy
);

    localparam int CNT_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (ACK_DELAY > 0) ? CNT_W'(ACK_DELAY - 1) : '0;

    respStateType      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s_ack_q;
    logic              capture;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   push_data;
    logic [DATA_W:0]   head;

    // Result mux: the tag is the Select value seen at the capture edge.
    assign push_data = {(Select == SRC_M2) ? M2_data : M1_data, Select};

    resp_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .push_i      (capture),
        .push_data_i (push_data),
        .pop_i       (out_ready),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // State, wait counter and acknowledge flop; S_ack is never combinational from S_req.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= RS_IDLE;
            cnt_q   <= '0;
            s_ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_ack_q <= capture;
        end
    end

    // Next-state logic: delay count, abandon detection and full-FIFO retry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            RS_IDLE: begin
                if (S_req) begin
                    if (ACK_DELAY == 0) begin
                        if (!fifo_full) begin
                            capture = 1'b1;
                            state_d = RS_ACK;
                        end else begin
                            state_d = RS_WAIT;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = RS_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            RS_WAIT: begin
                if (!S_req) begin
                    state_d = RS_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!fifo_full) begin
                    capture = 1'b1;
                    state_d = RS_ACK;
                end
            end
            RS_ACK: begin
                state_d = RS_IDLE;
            end
            default: begin
                state_d = RS_IDLE;
            end
        endcase
    end

    // Output decode from registered state and FIFO head.
    always_comb begin
        S_ack     = s_ack_q;
        busy      = (state_q != RS_IDLE);
        out_valid = ~fifo_empty;
        out_data  = head[DATA_W:1];
        out_src   = head[0];
    end

endmodule : fpu_result_responder

// File: tb/tb_fpu_result_responder.sv
// Directed bench for fpu_result_responder (DATA_W=32, DEPTH=4, ACK_DELAY=2).
module tb_fpu_result_responder;

    logic        CLK;
    logic        RSTn;
    logic        S_req;
    logic        Select;
    logic        S_ack;
    logic [31:0] M1_data;
    logic [31:0] M2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_src;
    logic [2:0]  fifo_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sel;
        logic [31:0] m1;
        logic [31:0] m2;
        logic        exp_src;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] drain_data [4];
    logic        drain_src  [4];
    logic [32:0] exp_q [$];

    fpu_result_responder #(
        .DATA_W    (32),
        .DEPTH     (4),
        .ACK_DELAY (2)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .S_req      (S_req),
        .Select     (Select),
        .S_ack      (S_ack),
        .M1_data    (M1_data),
        .M2_data    (M2_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where S_ack is seen, S_req then dropped.
    task automatic do_req(input logic sel, input logic [31:0] m1, input logic [31:0] m2,
                          output int lat);
        Select  = sel;
        M1_data = m1;
        M2_data = m2;
        S_req   = 1'b1;
        lat     = 0;
        while (1) begin
            @(negedge CLK);
            lat++;
            if (S_ack) break;
            if (lat >= 40) begin
                check("ack_timeout", S_ack, 1);
                break;
            end
        end
        S_req = 1'b0;
        $display("req sel=%0d m1=%h m2=%h ack_latency=%0d count=%0d", sel, m1, m2, lat, fifo_count);
    endtask

    task automatic do_reset();
        RSTn      = 1'b0;
        S_req     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        int lat;

        vecs[0] = '{1'b0, 32'h1000_0000, 32'h2000_0000, 1'b0, 32'h1000_0000};
        vecs[1] = '{1'b1, 32'h1000_0001, 32'h2000_0001, 1'b1, 32'h2000_0001};
        vecs[2] = '{1'b0, 32'h1000_0002, 32'h2000_0002, 1'b0, 32'h1000_0002};
        vecs[3] = '{1'b1, 32'h1000_0003, 32'h2000_0003, 1'b1, 32'h2000_0003};
        vecs[4] = '{1'b0, 32'h3F80_0000, 32'h4049_0FDB, 1'b0, 32'h3F80_0000};
        vecs[5] = '{1'b1, 32'h3F80_0000, 32'h4049_0FDB, 1'b1, 32'h4049_0FDB};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF};
        vecs[7] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000};

        drain_data[0] = 32'hB000_0001; drain_src[0] = 1'b1;
        drain_data[1] = 32'hA000_0002; drain_src[1] = 1'b0;
        drain_data[2] = 32'hB000_0003; drain_src[2] = 1'b1;
        drain_data[3] = 32'hA000_0004; drain_src[3] = 1'b0;

        // 1: reset with S_req held high
        RSTn = 1'b0; S_req = 1'b1; Select = 1'b0;
        M1_data = '0; M2_data = '0; out_ready = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("rst_ack", S_ack, 0);
            check("rst_valid", out_valid, 0);
            check("rst_count", fifo_count, 0);
            check("rst_busy", busy, 0);
        end
        RSTn = 1'b1;
        #1;
        check("post_rst_ack", S_ack, 0);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_count", fifo_count, 0);
        check("post_rst_busy", busy, 0);

        // 2: single M1 request, ACK_DELAY+1 latency
        do_reset();
        do_req(1'b0, 32'h3F80_0000, 32'h0, lat);
        check("t2_latency", lat, 3);
        check("t2_valid", out_valid, 1);
        check("t2_data", out_data, 32'h3F80_0000);
        check("t2_src", out_src, 0);
        check("t2_count", fifo_count, 1);
        @(negedge CLK);
        check("t2_ack_one_cycle", S_ack, 0);
        check("t2_busy_after", busy, 0);

        // 3: abandoned request
        do_reset();
        Select = 1'b1; M2_data = 32'h4049_0FDB; S_req = 1'b1;
        @(negedge CLK);
        check("t3_busy_wait", busy, 1);
        S_req = 1'b0;
        @(negedge CLK);
        check("t3_busy_idle", busy, 0);
        repeat (3) begin
            @(negedge CLK);
            check("t3_no_ack", S_ack, 0);
            check("t3_count", fifo_count, 0);
        end

        // 4: fill the FIFO, fifth request stalls until one pop
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_req(i[0], 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), lat);
            check("t4_latency", lat, 3);
            @(negedge CLK);
        end
        check("t4_count_full", fifo_count, 4);
        Select = 1'b0; M1_data = 32'hA000_0004; S_req = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            check("t4_held_no_ack", S_ack, 0);
        end
        check("t4_held_busy", busy, 1);
        check("t4_head", out_data, 32'hA000_0000);
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        check("t4_pop_no_ack", S_ack, 0);
        check("t4_count_after_pop", fifo_count, 3);
        @(negedge CLK);
        check("t4_late_ack", S_ack, 1);
        check("t4_count_refill", fifo_count, 4);
        S_req = 1'b0;
        $display("req sel=0 m1=a0000004 stalled then acked count=%0d", fifo_count);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("t4_drain_valid", out_valid, 1);
            check("t4_drain_data", out_data, drain_data[j]);
            check("t4_drain_src", out_src, drain_src[j]);
            @(negedge CLK);
        end
        check("t4_empty_count", fifo_count, 0);
        check("t4_empty_valid", out_valid, 0);

        // 5: alternating sources, table-driven, out_ready=1
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            do_req(vecs[k].sel, vecs[k].m1, vecs[k].m2, lat);
            check("t5_latency", lat, 3);
            check("t5_valid", out_valid, 1);
            check("t5_src", out_src, vecs[k].exp_src);
            check("t5_data", out_data, vecs[k].exp_data);
            @(negedge CLK);
            check("t5_no_consecutive_ack", S_ack, 0);
            check("t5_drained", out_valid, 0);
        end

        // 6: push+pop at count 2 across 2*DEPTH transfers
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            do_req(k[0], 32'hC000_0000 + 32'(k), 32'hC100_0000 + 32'(k), lat);
            exp_q.push_back({(k[0] ? 32'hC100_0000 : 32'hC000_0000) + 32'(k), k[0]});
            @(negedge CLK);
        end
        check("t6_start_count", fifo_count, 2);
        for (int k = 0; k < 8; k++) begin
            Select = k[0];
            M1_data = 32'hD000_0000 + 32'(k);
            M2_data = 32'hE000_0000 + 32'(k);
            S_req = 1'b1;
            @(negedge CLK);
            @(negedge CLK);
            check("t6_head_data", out_data, exp_q[0][32:1]);
            check("t6_head_src", out_src, exp_q[0][0]);
            out_ready = 1'b1;
            void'(exp_q.pop_front());
            exp_q.push_back({(k[0] ? 32'hE000_0000 : 32'hD000_0000) + 32'(k), k[0]});
            @(negedge CLK);
            check("t6_ack", S_ack, 1);
            check("t6_count_stays", fifo_count, 2);
            $display("req sel=%0d push+pop count=%0d", k[0], fifo_count);
            out_ready = 1'b0;
            S_req = 1'b0;
            @(negedge CLK);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            check("t6_drain_valid", out_valid, 1);
            check("t6_drain_data", out_data, exp_q[0][32:1]);
            check("t6_drain_src", out_src, exp_q[0][0]);
            void'(exp_q.pop_front());
            @(negedge CLK);
        end
        check("t6_final_count", fifo_count, 0);
        check("t6_final_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fpu_result_responder
